// File: rtl/bip_dbg_pkg.sv
// Shared command codes, response bytes and FSM state encoding for the BIP
// debug controller.
package bip_dbg_pkg;

   localparam logic [7:0] CMD_LOAD   = 8'h4C;
   localparam logic [7:0] CMD_RUN    = 8'h52;
   localparam logic [7:0] CMD_STEP   = 8'h53;
   localparam logic [7:0] CMD_DUMP   = 8'h44;

   localparam logic [7:0] ACK_CODE   = 8'h06;
   localparam logic [7:0] NAK_CODE   = 8'h15;
   localparam logic [7:0] ABORT_CODE = 8'h1B;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CNT_H,
      S_CNT_L,
      S_DAT_H,
      S_DAT_L,
      S_WRITE,
      S_RUN,
      S_STEP,
      S_DREAD,
      S_DLATCH,
      S_SEND_H,
      S_WAIT_H,
      S_SEND_L,
      S_WAIT_L,
      S_RESP,
      S_RESP_WAIT
   } state_t;

endpackage

// File: rtl/word_counter.sv
// Word index for load/dump transfers: up-counting index for the address bus,
// down-counting remainder with terminal-count compare for the last-word flag.
module word_counter #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] index,
   output logic              last
);

   logic [ADDR_W-1:0] remain;

   always_ff @(posedge clk) begin
      if (reset) begin
         index  <= '0;
         remain <= '0;
      end else if (load) begin
         index  <= '0;
         remain <= count;
      end else if (inc) begin
         index  <= index + ADDR_W'(1);
         remain <= remain - ADDR_W'(1);
      end
   end

   // count 0 never reaches here; the controller answers it directly
   assign last = (remain == ADDR_W'(1));

endmodule

// File: rtl/debug_ctrl.sv
// UART-driven debug controller for the BIP core: program load, run, single
// step and data-memory dump, each answered with ACK/NAK.
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | wait for a command byte
// CNT_H/CNT_L | receive 16-bit word count, high byte first
// DAT_H/DAT_L | receive one program word, high byte first
// WRITE       | one-cycle program-memory write strobe
// RUN         | BIP enabled until halt or abort byte
// STEP        | BIP enabled for a single cycle
// DREAD       | one-cycle data-memory read strobe
// DLATCH      | capture data-memory read word
// SEND_H/L    | start transmission of high/low dump byte
// WAIT_H/L    | wait for transmitter done
// RESP        | start transmission of ACK/NAK
// RESP_WAIT   | wait for transmitter done, then back to IDLE
module debug_ctrl
   import bip_dbg_pkg::*;
#(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_done,
   input  logic              tx_done,
   input  logic              halt,
   input  logic [DATA_W-1:0] dm_data,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   output logic              wr_pm,
   output logic              rd_dm,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              bip_reset,
   output logic              bip_en
);

   state_t            state, state_nx;
   logic [7:0]        cnt_hi, cnt_hi_nx;
   logic [7:0]        dat_hi, dat_hi_nx;
   logic [7:0]        resp, resp_nx;
   logic [DATA_W-1:0] word, word_nx;
   logic [DATA_W-1:0] wdata_q, wdata_nx;
   logic              is_load, is_load_nx;
   logic              bip_reset_q, bip_reset_nx;

   logic [ADDR_W-1:0] cnt_field;
   logic [ADDR_W-1:0] index;
   logic              cnt_load, cnt_inc, last;
   logic              abort_byte;

   // upper count bits beyond the address width are dropped
   assign cnt_field  = ADDR_W'({cnt_hi, rx_data});
   assign abort_byte = rx_done && (rx_data == ABORT_CODE);

   word_counter #(
      .ADDR_W (ADDR_W)
   ) u_word_counter (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .inc   (cnt_inc),
      .count (cnt_field),
      .index (index),
      .last  (last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt_hi      <= '0;
         dat_hi      <= '0;
         resp        <= '0;
         word        <= '0;
         wdata_q     <= '0;
         is_load     <= 1'b0;
         bip_reset_q <= 1'b1;
      end else begin
         state       <= state_nx;
         cnt_hi      <= cnt_hi_nx;
         dat_hi      <= dat_hi_nx;
         resp        <= resp_nx;
         word        <= word_nx;
         wdata_q     <= wdata_nx;
         is_load     <= is_load_nx;
         bip_reset_q <= bip_reset_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_hi_nx    = cnt_hi;
      dat_hi_nx    = dat_hi;
      resp_nx      = resp;
      word_nx      = word;
      wdata_nx     = wdata_q;
      is_load_nx   = is_load;
      bip_reset_nx = bip_reset_q;
      cnt_load     = 1'b0;
      cnt_inc      = 1'b0;
      wr_pm        = 1'b0;
      rd_dm        = 1'b0;
      tx_start     = 1'b0;
      tx_data      = '0;
      bip_en       = 1'b0;

      case (state)
         S_IDLE: begin
            if (rx_done) begin
               case (rx_data)
                  CMD_LOAD: begin
                     state_nx     = S_CNT_H;
                     is_load_nx   = 1'b1;
                     bip_reset_nx = 1'b1;
                  end
                  CMD_DUMP: begin
                     state_nx   = S_CNT_H;
                     is_load_nx = 1'b0;
                  end
                  CMD_RUN: begin
                     state_nx     = S_RUN;
                     bip_reset_nx = 1'b0;
                  end
                  CMD_STEP: begin
                     state_nx     = S_STEP;
                     bip_reset_nx = 1'b0;
                  end
                  default: begin
                     state_nx = S_RESP;
                     resp_nx  = NAK_CODE;
                  end
               endcase
            end
         end
         S_CNT_H: begin
            if (rx_done) begin
               cnt_hi_nx = rx_data;
               state_nx  = S_CNT_L;
            end
         end
         S_CNT_L: begin
            if (rx_done) begin
               cnt_load = 1'b1;
               if (cnt_field == '0) begin
                  state_nx = S_RESP;
                  resp_nx  = ACK_CODE;
               end else if (is_load) begin
                  state_nx = S_DAT_H;
               end else begin
                  state_nx = S_DREAD;
               end
            end
         end
         S_DAT_H: begin
            if (rx_done) begin
               dat_hi_nx = rx_data;
               state_nx  = S_DAT_L;
            end
         end
         S_DAT_L: begin
            if (rx_done) begin
               wdata_nx = DATA_W'({dat_hi, rx_data});
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_pm = 1'b1;
            if (last) begin
               state_nx = S_RESP;
               resp_nx  = ACK_CODE;
            end else begin
               cnt_inc  = 1'b1;
               state_nx = S_DAT_H;
            end
         end
         S_RUN: begin
            // halt wins over a simultaneous abort byte
            if (halt) begin
               state_nx = S_RESP;
               resp_nx  = ACK_CODE;
            end else begin
               bip_en = 1'b1;
               if (abort_byte) begin
                  state_nx = S_RESP;
                  resp_nx  = NAK_CODE;
               end
            end
         end
         S_STEP: begin
            bip_en   = 1'b1;
            state_nx = S_RESP;
            resp_nx  = ACK_CODE;
         end
         S_DREAD: begin
            rd_dm    = 1'b1;
            state_nx = S_DLATCH;
         end
         S_DLATCH: begin
            word_nx  = dm_data;
            state_nx = S_SEND_H;
         end
         S_SEND_H: begin
            tx_start = 1'b1;
            tx_data  = word[DATA_W-1 -: 8];
            state_nx = S_WAIT_H;
         end
         S_WAIT_H: begin
            tx_data = word[DATA_W-1 -: 8];
            if (tx_done) state_nx = S_SEND_L;
         end
         S_SEND_L: begin
            tx_start = 1'b1;
            tx_data  = word[7:0];
            state_nx = S_WAIT_L;
         end
         S_WAIT_L: begin
            tx_data = word[7:0];
            if (tx_done) begin
               if (last) begin
                  state_nx = S_RESP;
                  resp_nx  = ACK_CODE;
               end else begin
                  cnt_inc  = 1'b1;
                  state_nx = S_DREAD;
               end
            end
         end
         S_RESP: begin
            tx_start = 1'b1;
            tx_data  = resp;
            state_nx = S_RESP_WAIT;
         end
         S_RESP_WAIT: begin
            tx_data = resp;
            if (tx_done) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign addr      = index;
   assign wdata     = wdata_q;
   assign bip_reset = bip_reset_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench for debug_ctrl: directed and randomized command
// sequences compared against a transaction-level model of the protocol.
module tb_debug_ctrl;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 16;
   localparam int DM_N   = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_done;
   logic              tx_done = 1'b0;
   logic              halt;
   logic [DATA_W-1:0] dm_data = '0;
   logic [7:0]        tx_data;
   logic              tx_start;
   logic              wr_pm;
   logic              rd_dm;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              bip_reset;
   logic              bip_en;

   always #5 clk = ~clk;

   debug_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .tx_done   (tx_done),
      .halt      (halt),
      .dm_data   (dm_data),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .wr_pm     (wr_pm),
      .rd_dm     (rd_dm),
      .addr      (addr),
      .wdata     (wdata),
      .bip_reset (bip_reset),
      .bip_en    (bip_en)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic [15:0] dm_mem [DM_N];
   logic [15:0] ld_data [DM_N];
   wr_t         wr_log [$];
   logic [7:0]  tx_log [$];
   int          en_cycles = 0;
   int          excl_viol = 0;
   int          tx_delay  = 0;
   int          checks    = 0;
   int          errors    = 0;
   logic        model_bip_rst;

   // data memory answers one cycle after the read strobe
   always @(posedge clk) if (rd_dm) dm_data <= dm_mem[addr[3:0]];

   // transmitter: tx_done three cycles after each tx_start
   always @(posedge clk) begin
      tx_done <= 1'b0;
      if (tx_delay == 1) tx_done <= 1'b1;
      if (tx_delay > 0) tx_delay <= tx_delay - 1;
      else if (tx_start) tx_delay <= 3;
   end

   always @(negedge clk) begin
      if (wr_pm) wr_log.push_back({addr, wdata});
      if (tx_start) tx_log.push_back(tx_data);
      if (bip_en) en_cycles++;
      if ((int'(wr_pm) + int'(rd_dm) + int'(tx_start)) > 1) excl_viol++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
   endtask

   task automatic wait_tx(input int base, input int n);
      int cyc = 0;
      while (tx_log.size() < base + n && cyc < 4000) begin
         @(posedge clk);
         cyc++;
      end
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic run_load(input logic [15:0] cnt, input string tag);
      int n, tb0, wb0;
      n   = int'(cnt) % (1 << ADDR_W);
      tb0 = tx_log.size();
      wb0 = wr_log.size();
      send_byte(8'h4C);
      send_byte(cnt[15:8]);
      send_byte(cnt[7:0]);
      model_bip_rst = 1'b1;
      check($sformatf("%s_bip_reset_held", tag), 32'(bip_reset), 32'(1));
      for (int i = 0; i < n; i++) begin
         send_byte(ld_data[i][15:8]);
         send_byte(ld_data[i][7:0]);
      end
      wait_tx(tb0, 1);
      check($sformatf("%s_wr_count", tag), 32'(wr_log.size() - wb0), 32'(n));
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(wr_log[wb0 + i].a), 32'(i));
         check($sformatf("%s_data%0d", tag, i), 32'(wr_log[wb0 + i].d), 32'(ld_data[i]));
      end
      check($sformatf("%s_tx_count", tag), 32'(tx_log.size() - tb0), 32'(1));
      check($sformatf("%s_ack", tag), 32'(tx_log[tb0]), 32'h06);
   endtask

   task automatic run_dump(input logic [15:0] cnt, input string tag);
      int n, tb0, wb0;
      n   = int'(cnt) % (1 << ADDR_W);
      tb0 = tx_log.size();
      wb0 = wr_log.size();
      send_byte(8'h44);
      send_byte(cnt[15:8]);
      send_byte(cnt[7:0]);
      wait_tx(tb0, 2 * n + 1);
      check($sformatf("%s_tx_count", tag), 32'(tx_log.size() - tb0), 32'(2 * n + 1));
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_hi%0d", tag, i), 32'(tx_log[tb0 + 2 * i]), 32'(dm_mem[i][15:8]));
         check($sformatf("%s_lo%0d", tag, i), 32'(tx_log[tb0 + 2 * i + 1]), 32'(dm_mem[i][7:0]));
      end
      check($sformatf("%s_ack", tag), 32'(tx_log[tb0 + 2 * n]), 32'h06);
      check($sformatf("%s_no_write", tag), 32'(wr_log.size() - wb0), 32'(0));
      check($sformatf("%s_bip_reset", tag), 32'(bip_reset), 32'(model_bip_rst));
   endtask

   // k: enabled cycles before halt/abort; abort: end with 0x1B; same: halt with the abort byte
   task automatic run_cmd(input int k, input bit pre_halt, input bit abort,
                          input bit same, input string tag);
      int eb, tb0, exp_en;
      logic [7:0] exp_r;
      eb     = en_cycles;
      tb0    = tx_log.size();
      halt   = pre_halt;
      exp_en = 0;
      exp_r  = 8'h06;
      send_byte(8'h52);
      model_bip_rst = 1'b0;
      if (!pre_halt) begin
         repeat (k) @(posedge clk);
         #1;
         if (abort) begin
            rx_data = 8'h1B;
            rx_done = 1'b1;
            halt    = same;
            @(posedge clk); #1;
            rx_done = 1'b0;
            check($sformatf("%s_en_dropped", tag), 32'(bip_en), 32'(0));
            exp_en = same ? k : k + 1;
            exp_r  = same ? 8'h06 : 8'h15;
         end else begin
            halt   = 1'b1;
            exp_en = k;
         end
      end
      wait_tx(tb0, 1);
      halt = 1'b0;
      check($sformatf("%s_en_cycles", tag), 32'(en_cycles - eb), 32'(exp_en));
      check($sformatf("%s_tx_count", tag), 32'(tx_log.size() - tb0), 32'(1));
      check($sformatf("%s_resp", tag), 32'(tx_log[tb0]), 32'(exp_r));
      check($sformatf("%s_bip_reset", tag), 32'(bip_reset), 32'(0));
   endtask

   task automatic run_bad(input logic [7:0] b, input string tag);
      int tb0;
      tb0 = tx_log.size();
      send_byte(b);
      wait_tx(tb0, 1);
      check($sformatf("%s_tx_count", tag), 32'(tx_log.size() - tb0), 32'(1));
      check($sformatf("%s_nak", tag), 32'(tx_log[tb0]), 32'h15);
   endtask

   initial begin
      int tb0, wb0, eb, n, op;
      logic [7:0] b;
      rx_data = '0;
      rx_done = 1'b0;
      halt    = 1'b0;
      reset   = 1'b1;
      model_bip_rst = 1'b1;
      for (int i = 0; i < DM_N; i++) begin
         dm_mem[i]  = 16'($urandom);
         ld_data[i] = 16'($urandom);
      end
      dm_mem[0]  = 16'h0102;
      dm_mem[1]  = 16'hFFEE;
      ld_data[0] = 16'h1234;
      ld_data[1] = 16'hABCD;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_bip_reset", 32'(bip_reset), 32'(1));
      check("rst_bip_en",    32'(bip_en),    32'(0));
      check("rst_wr_pm",     32'(wr_pm),     32'(0));
      check("rst_rd_dm",     32'(rd_dm),     32'(0));
      check("rst_tx_start",  32'(tx_start),  32'(0));
      check("rst_tx_data",   32'(tx_data),   32'(0));
      check("rst_addr",      32'(addr),      32'(0));
      check("rst_wdata",     32'(wdata),     32'(0));

      run_bad(8'h7A, "bad_7a");
      run_dump(16'h0002, "dump2");
      run_load(16'h0002, "load2");
      run_load(16'h0000, "load0");
      run_dump(16'h0800, "dump_mask0");
      run_dump(16'hF801, "dump_mask1");

      run_cmd(5, 1'b0, 1'b0, 1'b0, "run5");
      run_cmd(0, 1'b1, 1'b0, 1'b0, "run_prehalt");
      run_cmd(3, 1'b0, 1'b1, 1'b0, "run_abort");
      run_cmd(2, 1'b0, 1'b1, 1'b1, "run_abort_halt");

      tb0 = tx_log.size();
      eb  = en_cycles;
      send_byte(8'h53);
      model_bip_rst = 1'b0;
      wait_tx(tb0, 1);
      check("step_en_cycles", 32'(en_cycles - eb), 32'(1));
      check("step_ack", 32'(tx_log[tb0]), 32'h06);
      check("step_bip_reset", 32'(bip_reset), 32'(0));

      // second byte lands while the NAK is still being sent and must vanish
      tb0 = tx_log.size();
      eb  = en_cycles;
      send_byte(8'h7A);
      send_byte(8'h52);
      wait_tx(tb0, 1);
      check("drop_tx_count", 32'(tx_log.size() - tb0), 32'(1));
      check("drop_nak", 32'(tx_log[tb0]), 32'h15);
      check("drop_no_run", 32'(en_cycles - eb), 32'(0));

      for (int it = 0; it < 8; it++) begin
         op = int'($urandom_range(0, 3));
         n  = int'($urandom_range(1, 6));
         case (op)
            0: begin
               for (int i = 0; i < n; i++) ld_data[i] = 16'($urandom);
               run_load(16'(($urandom_range(0, 31) << ADDR_W) | n), $sformatf("rnd%0d_load", it));
            end
            1: run_dump(16'(($urandom_range(0, 31) << ADDR_W) | n), $sformatf("rnd%0d_dump", it));
            2: run_cmd(int'($urandom_range(0, 9)), 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                       $sformatf("rnd%0d_run", it));
            default: begin
               do b = 8'($urandom_range(0, 255));
               while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h44);
               run_bad(b, $sformatf("rnd%0d_bad", it));
            end
         endcase
      end

      // reset while waiting for the low byte of the second load word
      send_byte(8'h4C);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      tb0 = tx_log.size();
      wb0 = wr_log.size();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      model_bip_rst = 1'b1;
      check("midrst_bip_reset", 32'(bip_reset), 32'(1));
      check("midrst_bip_en", 32'(bip_en), 32'(0));
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_tx", 32'(tx_log.size() - tb0), 32'(0));
      check("midrst_no_write", 32'(wr_log.size() - wb0), 32'(0));
      run_bad(8'h7A, "midrst_idle");
      check("midrst_still_no_write", 32'(wr_log.size() - wb0), 32'(0));
      check("midrst_bip_reset_kept", 32'(bip_reset), 32'(1));

      check("strobe_exclusive", 32'(excl_viol), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning memory address width for both program memory (PM) and data memory (DM).
REQ-002 SHALL have parameter DATA_W, default 16, meaning BIP word width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports rx_data  in  8  received UART byte; rx_done  in  1  one-cycle pulse, rx_data valid.
REQ-006 SHALL have ports tx_done  in  1  one-cycle pulse, previous byte sent; halt  in  1  level, BIP executed HLT.
REQ-007 SHALL have port dm_data  in  DATA_W  DM read data, valid one cycle after rd_dm.
REQ-008 SHALL have ports tx_data  out  8  byte to send; tx_start  out  1  one-cycle send request.
REQ-009 SHALL have ports wr_pm  out  1  PM write strobe; rd_dm  out  1  DM read strobe; addr  out  ADDR_W  PM/DM address; wdata  out  DATA_W  PM write data.
REQ-010 SHALL have ports bip_reset  out  1  holds BIP in reset; bip_en  out  1  BIP clock enable.

Function
REQ-011 SHALL decode command bytes in IDLE: 0x4C 'L' load, 0x52 'R' run, 0x53 'S' step, 0x44 'D' dump; any other byte SHALL return NAK 0x15.
REQ-012 SHALL implement states IDLE, CNT_H, CNT_L, DAT_H, DAT_L, WRITE, RUN, STEP, DREAD, DLATCH, SEND_H, WAIT_H, SEND_L, WAIT_L, RESP, RESP_WAIT.
REQ-013 'L' and 'D' SHALL take a 2-byte count, high byte first, into CNT_H/CNT_L; count[ADDR_W-1:0] used, upper bits ignored.
REQ-014 Count 0 SHALL go directly to RESP with ACK 0x06, no memory access.
REQ-015 Load: per word, receive high byte (DAT_H) then low byte (DAT_L); in WRITE, wr_pm SHALL be 1 for exactly one cycle with addr = word index (0..N-1) and wdata = {high,low}.
REQ-016 Load SHALL assert bip_reset from 'L' accepted until ACK sent; after the last write, go to RESP with ACK.
REQ-017 Run: bip_reset=0, bip_en=1 each cycle in RUN until halt=1, then bip_en=0 and ACK.
REQ-018 halt already 1 on RUN entry SHALL give zero enabled cycles and immediate ACK.
REQ-019 rx_done with rx_data=0x1B in RUN SHALL abort: bip_en=0, NAK; halt and abort in the same cycle SHALL resolve to ACK.
REQ-020 Step: bip_reset=0, bip_en=1 for exactly one cycle, then ACK.
REQ-021 Dump: per word, rd_dm=1 one cycle (DREAD, addr=index), latch dm_data in DLATCH, send high byte then low byte, each tx_start one-cycle pulse followed by wait for tx_done.
REQ-022 After the N-th word the dump SHALL end with ACK, giving 2N+1 bytes total.
REQ-023 RESP SHALL pulse tx_start once with tx_data=ACK/NAK; RESP_WAIT SHALL return to IDLE on tx_done.
REQ-024 rx_done in any state not awaiting a byte (WRITE, STEP, DREAD..WAIT_L, RESP, RESP_WAIT) SHALL be ignored and the byte dropped.
REQ-025 Word index SHALL wrap from 2^ADDR_W-1 to 0; count field 0 is not treated as 2^ADDR_W.
REQ-026 wr_pm, rd_dm and tx_start SHALL never be asserted in the same cycle.

Reset
REQ-027 reset SHALL force IDLE, bip_reset=1, bip_en=0, wr_pm=0, rd_dm=0, tx_start=0, tx_data=0, addr=0, wdata=0, and clear counters, taking effect at the next edge in any state.
REQ-028 reset asserted mid-load or mid-dump SHALL abandon the transfer with no further strobes and no response byte.
REQ-029 After reset, bip_reset SHALL stay 1 until the first 'R' or 'S' command.

Structure
REQ-030 Command codes, ACK/NAK/abort values and state encodings SHALL live in shared package bip_dbg_pkg.
REQ-031 The word index/count compare SHALL be the sub-module word_counter (load, increment, last flag).

Verification
REQ-032 'L',0x00,0x02,0x12,0x34,0xAB,0xCD -> wr_pm pulses at addr 0 wdata 0x1234 and addr 1 wdata 0xABCD, then tx 0x06.
REQ-033 'D',0x00,0x02 with DM[0]=0x0102, DM[1]=0xFFEE -> tx 0x01,0x02,0xFF,0xEE,0x06.
REQ-034 'R' with halt rising after 5 cycles -> bip_en high exactly 5 cycles, tx 0x06; 'R' with halt already 1 -> bip_en never high, tx 0x06.
REQ-035 'R' then 0x1B before halt -> bip_en drops next cycle, tx 0x15; 0x1B and halt in the same cycle -> tx 0x06.
REQ-036 Byte 0x7A in IDLE -> tx 0x15; reset during DAT_L of a load -> no wr_pm, no tx, IDLE with bip_reset=1.
